// File: rtl/test_pattern_pkg.sv
// rtl/test_pattern_pkg.sv - shared types and constants for the test pattern generator
package test_pattern_pkg;

    typedef enum logic [2:0] {
        BARS   = 3'd0,
        GRAD   = 3'd1,
        CHECK  = 3'd2,
        BORDER = 3'd3,
        BOX    = 3'd4
    } pattern_e;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_fsm_e;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_LUT [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam logic [23:0] BOX_BG = 24'h202020;

    // Out-of-range selects fall back to the colour bars.
    function automatic pattern_e to_pattern(input logic [2:0] sel);
        return (sel > 3'd4) ? BARS : pattern_e'(sel);
    endfunction

endpackage

// File: rtl/pattern_box_mover.sv
// rtl/pattern_box_mover.sv - one axis of bouncing-box position and direction
module pattern_box_mover
    import test_pattern_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic       tick,
    input  logic [9:0] screen_size,
    output logic [9:0] pos
);

    logic       dir;
    logic [10:0] reach;

    assign reach = {1'b0, pos} + 11'(BOX_SIZE + BOX_STEP);

    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) begin
            pos <= '0;
            dir <= DIR_POS;
        end else if (tick) begin
            if (dir == DIR_POS) begin
                if (reach > {1'b0, screen_size}) begin
                    pos <= screen_size - 10'(BOX_SIZE);
                    dir <= DIR_NEG;
                end else begin
                    pos <= pos + 10'(BOX_STEP);
                end
            end else begin
                if (pos < 10'(BOX_STEP)) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - 10'(BOX_STEP);
                end
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - five-pattern video test source with auto-cycle and bouncing box
module test_pattern_gen
    import test_pattern_pkg::*;
#(
    parameter int BAR_W           = 80,
    parameter int CHECK_LOG2      = 5,
    parameter int BOX_SIZE        = 32,
    parameter int BOX_STEP        = 2,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic        clk_pix,
    input  logic        rst_in,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic [9:0]  frame_width,
    input  logic [9:0]  frame_height,
    input  logic [9:0]  screen_start_x,
    input  logic [9:0]  screen_start_y,
    input  logic [9:0]  screen_width,
    input  logic [9:0]  screen_height,
    input  logic [2:0]  mode_sel,
    input  logic        auto_cycle,
    output logic [23:0] rgb,
    output logic [2:0]  mode,
    output logic        frame_tick
);

    localparam int CW = $clog2(BAR_W);
    localparam int DW = $clog2(FRAMES_PER_MODE + 1);

    logic          visible;
    logic          last_px;
    logic [9:0]    rx;
    logic [9:0]    ry;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    bar_q, bar_d;
    logic [7:0]    frame_cnt;
    logic [DW-1:0] dwell;
    mode_fsm_e     fsm;
    pattern_e      cur_mode;
    logic [9:0]    bx, by;
    logic [10:0]   bx_end, by_end;
    logic          in_box;
    logic [23:0]   pix;

    assign visible = (cx >= screen_start_x) && (cy >= screen_start_y);
    assign rx      = cx - screen_start_x;
    assign ry      = cy - screen_start_y;
    assign last_px = (cx == frame_width - 10'd1) && (cy == frame_height - 10'd1);
    assign mode    = cur_mode;

    // Bar index follows a column counter so no divider is needed; it
    // relies on cx advancing one pixel per clock across the line.
    always_comb begin
        col_d = col_q + 1'b1;
        bar_d = bar_q;
        if (rx == 10'd0) begin
            col_d = '0;
            bar_d = 3'd0;
        end else if (col_q == CW'(BAR_W - 1)) begin
            col_d = '0;
            bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) begin
            col_q <= '0;
            bar_q <= '0;
        end else begin
            col_q <= col_d;
            bar_q <= bar_d;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) begin
            frame_cnt <= '0;
            dwell     <= '0;
            fsm       <= MANUAL;
            cur_mode  <= BARS;
        end else if (last_px) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (!auto_cycle) begin
                fsm      <= MANUAL;
                cur_mode <= to_pattern(mode_sel);
            end else if (fsm == MANUAL) begin
                fsm   <= AUTO;
                dwell <= '0;
            end else if (dwell == DW'(FRAMES_PER_MODE - 1)) begin
                dwell    <= '0;
                cur_mode <= (cur_mode == BOX) ? BARS : pattern_e'(3'(cur_mode) + 3'd1);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    pattern_box_mover #(.BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) u_box_x (
        .clk_pix     (clk_pix),
        .rst_in      (rst_in),
        .tick        (last_px),
        .screen_size (screen_width),
        .pos         (bx)
    );

    pattern_box_mover #(.BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) u_box_y (
        .clk_pix     (clk_pix),
        .rst_in      (rst_in),
        .tick        (last_px),
        .screen_size (screen_height),
        .pos         (by)
    );

    assign bx_end = {1'b0, bx} + 11'(BOX_SIZE);
    assign by_end = {1'b0, by} + 11'(BOX_SIZE);
    assign in_box = (rx >= bx) && (ry >= by) && ({1'b0, rx} < bx_end) && ({1'b0, ry} < by_end);

    always_comb begin
        pix = 24'h000000;
        case (cur_mode)
            BARS:   pix = BAR_LUT[bar_d];
            GRAD:   pix = {rx[7:0], ry[7:0], frame_cnt};
            CHECK:  pix = (rx[CHECK_LOG2] ^ ry[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            BORDER: begin
                if (rx == 10'd0)
                    pix = 24'hFF0000;
                else if (ry == 10'd0)
                    pix = 24'h00FF00;
                else if ((rx == screen_width - 10'd1) || (ry == screen_height - 10'd1))
                    pix = 24'h0000FF;
            end
            BOX:    pix = in_box ? 24'hFFFFFF : BOX_BG;
            default: pix = 24'h000000;
        endcase
        if (!visible)
            pix = 24'h000000;
    end

    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) begin
            rgb        <= '0;
            frame_tick <= 1'b0;
        end else begin
            rgb        <= pix;
            frame_tick <= last_px;
        end
    end

endmodule
